relu_layer_ctrl: RTL and testbench

//  Sequences one ReLU layer pass in the accelerator. On start it reads LEN words from on-chip SRAM at
//  SRC_BASE and streams them into the ReLU datapath (DI_valid/DI). It writes each ReLU result
//  (DO_valid/DO) back to SRAM at DST_BASE in order. It asserts busy during the pass and pulses done when it ends.

---
 rtl/relu_layer_ctrl.sv | 127 ++++++++++++
 tb/tb_relu_layer_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_layer_ctrl.sv
// One ReLU layer pass: SRAM read -> ReLU datapath -> SRAM write, 1 word/cycle, read-to-write latency 2 cycles, no backpressure.
// Defining RELU_CTRL_CYCLE_CNT_EN adds the cyc_cnt output (busy/done cycle counter).
module relu_layer_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 12,
  parameter int MAX_INFL  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_base,
  input  logic [ADDR_W-1:0]    dst_base,
  input  logic [ADDR_W-1:0]    len,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [WORD_SIZE-1:0] rd_data,
  output logic                 relu_di_valid,
  output logic [WORD_SIZE-1:0] relu_di,
  input  logic                 relu_do_valid,
  input  logic [WORD_SIZE-1:0] relu_do,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [WORD_SIZE-1:0] wr_data
`ifdef RELU_CTRL_CYCLE_CNT_EN
  ,
  output logic [31:0]          cyc_cnt
`endif
);

  localparam int IW = $clog2(MAX_INFL + 1);
  localparam logic [IW-1:0] MAX_I = IW'(MAX_INFL);
  localparam logic [IW-1:0] ONE_I = IW'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_src, r_dst, r_len, r_rd_cnt, r_wr_cnt, r_rd_addr;
  logic [IW-1:0]     r_infl;
  logic              r_busy, r_done, r_rd_en, r_di_vld;

  logic              w_accept, w_active, w_wr, w_rd_en_nxt;
  logic [ADDR_W-1:0] w_src_nxt, w_len_nxt, w_rd_cnt_nxt, w_wr_cnt_nxt;
  logic [IW-1:0]     w_infl_nxt;

  always_comb begin
    w_accept     = start && (r_state == S_IDLE);
    w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
    // Stray results with nothing outstanding are dropped
    w_wr         = relu_do_valid && w_active && (r_infl != '0);
    w_src_nxt    = w_accept ? src_base : r_src;
    w_len_nxt    = w_accept ? len : r_len;
    w_rd_cnt_nxt = w_accept ? '0 : (r_rd_en ? r_rd_cnt + ONE_A : r_rd_cnt);
    w_wr_cnt_nxt = w_accept ? '0 : (w_wr ? r_wr_cnt + ONE_A : r_wr_cnt);
    w_infl_nxt   = r_infl;
    if (w_accept)              w_infl_nxt = '0;
    else if (r_rd_en && !w_wr) w_infl_nxt = r_infl + ONE_I;
    else if (!r_rd_en && w_wr) w_infl_nxt = r_infl - ONE_I;

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (len != '0) ? S_RUN : S_DRAIN;
      S_RUN:   if (w_rd_cnt_nxt == r_len) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_wr_cnt_nxt == r_len) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Read strobe is registered, so it is decided one cycle ahead from next-state values
    w_rd_en_nxt = (w_state_nxt == S_RUN) && (w_rd_cnt_nxt < w_len_nxt) && (w_infl_nxt < MAX_I);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_rd_addr <= '0;
      r_infl    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_di_vld  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_src     <= w_src_nxt;
      r_len     <= w_len_nxt;
      if (w_accept) r_dst <= dst_base;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_wr_cnt  <= w_wr_cnt_nxt;
      r_rd_addr <= w_src_nxt + w_rd_cnt_nxt;
      r_infl    <= w_infl_nxt;
      r_busy    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done    <= (w_state_nxt == S_DONE);
      r_rd_en   <= w_rd_en_nxt;
      r_di_vld  <= r_rd_en;
    end
  end

`ifdef RELU_CTRL_CYCLE_CNT_EN
  logic [31:0] r_cyc_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_cyc_cnt <= '0;
    else if (w_accept)          r_cyc_cnt <= '0;
    else if (r_state != S_IDLE) r_cyc_cnt <= r_cyc_cnt + 32'd1;
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

  assign busy          = r_busy;
  assign done          = r_done;
  assign rd_en         = r_rd_en;
  assign rd_addr       = r_rd_addr;
  assign relu_di_valid = r_di_vld;
  assign relu_di       = rd_data;
  assign wr_en         = w_wr;
  assign wr_addr       = r_dst + r_wr_cnt;
  assign wr_data       = relu_do;

endmodule

// File: tb/tb_relu_layer_ctrl.sv
// Bench for relu_layer_ctrl: SRAM and ReLU stage models, randomized passes checked against a ReLU reference.
module tb_relu_layer_ctrl;
  localparam int WS = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_base = '0, dst_base = '0, len = '0;
  logic          busy, done, rd_en, relu_di_valid, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [WS-1:0] rd_data = '0, relu_di, wr_data;
  logic          r_dov, inj_dov = 1'b0;
  logic [WS-1:0] r_do;
  logic          relu_do_valid;
`ifdef RELU_CTRL_CYCLE_CNT_EN
  logic [31:0]   cyc_cnt;
`endif

  assign relu_do_valid = r_dov | inj_dov;

  always #5 clk = ~clk;

  relu_layer_ctrl #(.WORD_SIZE(WS), .ADDR_W(AW), .MAX_INFL(4)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base), .len(len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .relu_di_valid(relu_di_valid), .relu_di(relu_di), .relu_do_valid(relu_do_valid), .relu_do(r_do),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef RELU_CTRL_CYCLE_CNT_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  logic [WS-1:0] mem  [4096];
  logic [WS-1:0] gold [4096];

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dov <= 1'b0;
      r_do  <= '0;
    end else begin
      r_dov <= relu_di_valid;
      r_do  <= relu_di[WS-1] ? '0 : relu_di;
    end
  end

  typedef struct packed { logic [AW-1:0] a; logic [WS-1:0] d; } wr_t;
  wr_t           q_wr[$];
  logic [AW-1:0] q_rd[$];

  always @(negedge clk) begin
    if (wr_en) q_wr.push_back({wr_addr, wr_data});
    if (rd_en) q_rd.push_back(rd_addr);
  end

  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [WS-1:0] relu_ref(input logic [WS-1:0] x);
    int v;
    v = (int'(x) >= 32768) ? int'(x) - 65536 : int'(x);
    return (v < 0) ? WS'(0) : WS'(v);
  endfunction

  // Runs one pass; start re-pulsed with junk operands in cycles x1/x2. Cycle k = k edges after start.
  task automatic do_pass(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l,
                         input int x1, input int x2, output int dcyc, output int bcyc, output int ndone);
    dcyc = -1; bcyc = 0; ndone = 0;
    gold = mem;
    @(negedge clk);
    q_wr.delete(); q_rd.delete();
    src_base = s; dst_base = d; len = l; start = 1'b1;
    for (int k = 1; k <= int'(l) + 40; k++) begin
      @(negedge clk);
      start = (k == x1) || (k == x2);
      if (start) begin
        src_base = AW'($urandom); dst_base = AW'($urandom); len = AW'($urandom);
      end
      if (busy) bcyc++;
      if (done) begin
        ndone++;
        if (dcyc < 0) dcyc = k;
      end
      if (dcyc >= 0 && k >= dcyc + 2) break;
    end
    start = 1'b0;
    n_cmp++;
    if (dcyc < 0) begin
      n_fail++;
      $display("FAIL pass_timeout: no done within %0d cycles (len=%0d)", int'(l) + 40, l);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, rd_en, relu_di_valid, wr_en} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, rd_en, relu_di_valid, wr_en});
    end
    n_cmp++;
    if (rd_addr !== '0 || wr_addr !== '0) begin
      n_fail++; $display("FAIL reset_addr: got rd=%h wr=%h want 000/000", rd_addr, wr_addr);
    end
`ifdef RELU_CTRL_CYCLE_CNT_EN
    n_cmp++;
    if (cyc_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cyc: got %0d want 0", cyc_cnt); end
`endif
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc, bc, nd;
    logic [WS-1:0] exp_d [4];
    mem[12'h010] = 16'hFFFD; mem[12'h011] = 16'h0005; mem[12'h012] = 16'h0000; mem[12'h013] = 16'h8000;
    exp_d[0] = 16'h0; exp_d[1] = 16'h5; exp_d[2] = 16'h0; exp_d[3] = 16'h0;
    do_pass(12'h010, 12'h100, 12'd4, 0, 0, dc, bc, nd);
    n_cmp++;
    if (dc !== 7) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 7", dc); end
    n_cmp++;
    if (bc !== 6) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 6", bc); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[12'h100 + i] !== exp_d[i]) begin
        n_fail++; $display("FAIL basic_mem[%0d]: got %h want %h", i, mem[12'h100 + i], exp_d[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    int dc, bc, nd;
    do_pass(12'h123, 12'h456, 12'd0, 0, 0, dc, bc, nd);
    n_cmp++;
    if (q_rd.size() != 0 || q_wr.size() != 0) begin
      n_fail++; $display("FAIL len0_traffic: got rd=%0d wr=%0d want 0/0", q_rd.size(), q_wr.size());
    end
    n_cmp++;
    if (dc !== 2 || bc !== 1 || nd !== 1) begin
      n_fail++; $display("FAIL len0_timing: got done@%0d busy=%0d ndone=%0d want 2/1/1", dc, bc, nd);
    end
  endtask

  task automatic test_restart_ignored();
    int dc, bc, nd;
    logic [AW-1:0] ea;
    logic [WS-1:0] ed;
    for (int i = 0; i < 8; i++) mem[12'h500 + i] = WS'($urandom);
    do_pass(12'h500, 12'hA00, 12'd8, 2, 5, dc, bc, nd);
    n_cmp++;
    if (nd !== 1 || dc !== 11) begin
      n_fail++; $display("FAIL restart_done: got ndone=%0d done@%0d want 1/11", nd, dc);
    end
    n_cmp++;
    if (q_wr.size() != 8) begin n_fail++; $display("FAIL restart_nwr: got %0d want 8", q_wr.size()); end
    for (int i = 0; i < q_wr.size() && i < 8; i++) begin
      ea = AW'(12'hA00 + i); ed = relu_ref(gold[AW'(12'h500 + i)]);
      n_cmp++;
      if (q_wr[i] !== {ea, ed}) begin
        n_fail++; $display("FAIL restart_wr[%0d]: got %h/%h want %h/%h", i, q_wr[i].a, q_wr[i].d, ea, ed);
      end
    end
`ifdef RELU_CTRL_CYCLE_CNT_EN
    n_cmp++;
    if (cyc_cnt !== 32'd11) begin n_fail++; $display("FAIL restart_cyc: got %0d want 11", cyc_cnt); end
`endif
  endtask

  task automatic test_wrap();
    int dc, bc, nd;
    logic [AW-1:0] ea;
    do_pass(12'hFFE, 12'hFFE, 12'd4, 0, 0, dc, bc, nd);
    n_cmp++;
    if (q_rd.size() != 4 || q_wr.size() != 4) begin
      n_fail++; $display("FAIL wrap_count: got rd=%0d wr=%0d want 4/4", q_rd.size(), q_wr.size());
    end
    for (int i = 0; i < 4 && i < q_rd.size() && i < q_wr.size(); i++) begin
      ea = AW'(12'hFFE + i);
      n_cmp++;
      if (q_rd[i] !== ea || q_wr[i].a !== ea) begin
        n_fail++; $display("FAIL wrap_addr[%0d]: got rd=%h wr=%h want %h", i, q_rd[i], q_wr[i].a, ea);
      end
      n_cmp++;
      if (mem[ea] !== relu_ref(gold[ea])) begin
        n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, mem[ea], relu_ref(gold[ea]));
      end
    end
  endtask

  task automatic test_abort();
    int dc, bc, nd;
    @(negedge clk);
    src_base = 12'h200; dst_base = 12'h600; len = 12'd16; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, rd_en, relu_di_valid, wr_en} !== 5'b0 || rd_addr !== '0 || wr_addr !== '0) begin
      n_fail++; $display("FAIL abort_outputs: got ctrl=%b rd=%h wr=%h want 0", {busy, done, rd_en, relu_di_valid, wr_en}, rd_addr, wr_addr);
    end
    rst = 1'b1;
    mem[12'h300] = 16'h8123; mem[12'h301] = 16'h1234;
    do_pass(12'h300, 12'h700, 12'd2, 0, 0, dc, bc, nd);
    n_cmp++;
    if (dc !== 5 || q_wr.size() != 2) begin
      n_fail++; $display("FAIL abort_rerun: got done@%0d nwr=%0d want 5/2", dc, q_wr.size());
    end
    n_cmp++;
    if (mem[12'h700] !== 16'h0000 || mem[12'h701] !== 16'h1234) begin
      n_fail++; $display("FAIL abort_rerun_data: got %h %h want 0000 1234", mem[12'h700], mem[12'h701]);
    end
  endtask

  task automatic test_stray_valid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); inj_dov = 1'b1;
      #1;
      n_cmp++;
      if (wr_en !== 1'b0) begin n_fail++; $display("FAIL stray_wr_en[%0d]: got %b want 0", i, wr_en); end
    end
    @(negedge clk); inj_dov = 1'b0;
  endtask

  task automatic test_inplace();
    int dc, bc, nd;
    for (int i = 0; i < 6; i++) mem[12'h040 + i] = {i[0], 15'($urandom)};
    do_pass(12'h040, 12'h040, 12'd6, 0, 0, dc, bc, nd);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (mem[12'h040 + i] !== relu_ref(gold[12'h040 + i])) begin
        n_fail++; $display("FAIL inplace[%0d]: got %h want %h", i, mem[12'h040 + i], relu_ref(gold[12'h040 + i]));
      end
    end
`ifdef RELU_CTRL_CYCLE_CNT_EN
    n_cmp++;
    if (cyc_cnt !== 32'd9) begin n_fail++; $display("FAIL inplace_cyc: got %0d want 9", cyc_cnt); end
`endif
  endtask

  task automatic test_random_passes();
    int dc, bc, nd, l;
    logic [AW-1:0] s, d, ea;
    logic [WS-1:0] ed;
    for (int it = 0; it < 8; it++) begin
      l = $urandom_range(1, 40);
      s = AW'($urandom);
      d = (it % 3 == 2) ? s : AW'(s + 12'h800);
      do_pass(s, d, AW'(l), 0, 0, dc, bc, nd);
      n_cmp++;
      if (dc !== l + 3 || bc !== l + 2 || nd !== 1) begin
        n_fail++; $display("FAIL rand%0d_timing: got done@%0d busy=%0d ndone=%0d want %0d/%0d/1", it, dc, bc, nd, l + 3, l + 2);
      end
      n_cmp++;
      if (q_wr.size() != l || q_rd.size() != l) begin
        n_fail++; $display("FAIL rand%0d_count: got rd=%0d wr=%0d want %0d", it, q_rd.size(), q_wr.size(), l);
      end
      for (int i = 0; i < l && i < q_wr.size() && i < q_rd.size(); i++) begin
        ea = AW'(d + i); ed = relu_ref(gold[AW'(s + i)]);
        n_cmp++;
        if (q_wr[i] !== {ea, ed} || q_rd[i] !== AW'(s + i)) begin
          n_fail++; $display("FAIL rand%0d_beat%0d: got rd=%h wr=%h/%h want %h %h/%h", it, i, q_rd[i], q_wr[i].a, q_wr[i].d, AW'(s + i), ea, ed);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = WS'($urandom);
    test_reset();
    test_basic();
    test_len_zero();
    test_restart_ignored();
    test_wrap();
    test_abort();
    test_stray_valid();
    test_inplace();
    test_random_passes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
